bus_tx_framer: RTL and testbench

Packet framer that sits directly upstream of the shared data bus interface's send port. It accepts a packet request (destination, opcode, payload length) and a stream of payload bytes into an internal FIFO. It then emits one header byte followed by the payload bytes on the `send_valid`/`send_ready` handshake, and pulses `ack` to mark end-of-packet. This lets crypto cores hand off whole packets without tracking bus ownership or header encoding.

---
 rtl/bus_tx_framer.sv | 177 +++++++++++++++++
 tb/tb_bus_tx_framer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_tx_framer.sv
// bus_tx_framer: frames queued payload bytes behind a one-byte header on the
// send_valid/send_ready port and pulses ack at end of packet.
// Optional stall timeout is built when TX_TIMEOUT_EN is defined; the
// TIMEOUT_CYC parameter exists only in that build.
module bus_tx_framer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_W      = 8
`ifdef TX_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       src_id,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_dest,
    input  logic [1:0]       req_op,
    input  logic [LEN_W-1:0] req_len,
    input  logic             pay_valid,
    input  logic [7:0]       pay_data,
    output logic             pay_ready,
    output logic             send_valid,
    output logic [7:0]       send_data,
    input  logic             send_ready,
    output logic             ack,
    output logic             busy,
    output logic             err_timeout
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       dest_q, op_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_empty, push, pop, hdr_beat, abort;

    assign fifo_empty = (count == '0);
    assign pay_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign push       = pay_valid && pay_ready;
    assign hdr_beat   = (state == S_HDR) && send_ready;
    assign pop        = (state == S_PAY) && !fifo_empty && send_ready;

    // Outputs decoded from state/FIFO registers only; send_ready never feeds them
    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign ack        = (state == S_DONE);
    assign send_valid = (state == S_HDR) || ((state == S_PAY) && !fifo_empty);
    assign send_data  = (state == S_HDR) ? {2'b00, dest_q, src_id, op_q} :
                        ((state == S_PAY) && !fifo_empty) ? mem[rd_ptr] : 8'h00;

    // Next-state and remaining-length logic
    always_comb begin
        state_d = state;
        rem_d   = rem_q;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_HDR;
                    rem_d   = req_len;
                end
            end
            S_HDR: begin
                if (hdr_beat) begin
                    state_d = (rem_q != '0) ? S_PAY : S_DONE;
                end
            end
            S_PAY: begin
                if (pop) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_DONE;
        end
    end

    // State, length and latched header fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rem_q  <= '0;
            dest_q <= '0;
            op_q   <= '0;
        end else begin
            state <= state_d;
            rem_q <= rem_d;
            if ((state == S_IDLE) && req_valid) begin
                dest_q <= req_dest;
                op_q   <= req_op;
            end
        end
    end

    // FIFO pointers and occupancy; an abort flushes everything queued
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage, no reset needed since reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pay_data;
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               err_q;
    logic               stall;

    assign stall = ((state == S_HDR) || (state == S_PAY)) && send_valid && !send_ready;
    assign abort = stall && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
    assign err_timeout = err_q;

    // Stall counter, cleared on any beat or outside the sending states
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (abort || hdr_beat || pop ||
                     !((state == S_HDR) || (state == S_PAY))) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    // Sticky timeout flag, cleared when the next request is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && req_valid) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end
`else
    assign abort       = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_tx_framer.sv
// tb_bus_tx_framer: directed plus randomized checks of bus_tx_framer against
// a queue-based model of the packet stream (header + next L payload bytes).
module tb_bus_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] src_id;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_dest;
    logic [1:0] req_op;
    logic [7:0] req_len;
    logic       pay_valid;
    logic [7:0] pay_data;
    logic       pay_ready;
    logic       send_valid;
    logic [7:0] send_data;
    logic       send_ready;
    logic       ack;
    logic       busy;
    logic       err_timeout;

    bus_tx_framer #(.FIFO_DEPTH(16), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .src_id(src_id),
        .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
        .req_op(req_op), .req_len(req_len),
        .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready),
        .send_valid(send_valid), .send_data(send_data), .send_ready(send_ready),
        .ack(ack), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: every accepted payload byte in order, and the packets requested
    logic [7:0] pushed[$];
    int         cons = 0;
    logic [7:0] pkt_hdr[$];
    int         pkt_len[$];
    int         exp_acks = 0;

    // Observed bus beats and ack pulses
    logic [7:0] sent_q[$];
    int         sent_base = 0;
    int         ack_cnt = 0;
    int         cyc = 0;
    int         ack_cyc = -100;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (send_valid === 1'b1 && send_ready === 1'b1) sent_q.push_back(send_data);
        if (ack === 1'b1) begin
            ack_cnt <= ack_cnt + 1;
            ack_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int g = 0;
        pay_valid = 1'b1;
        pay_data  = b;
        while (!pay_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!pay_ready) chk("push_timeout", 32'(pay_ready), 32'(1));
        else pushed.push_back(b);
        @(negedge clk);
        pay_valid = 1'b0;
    endtask

    task automatic request(input logic [1:0] d, input logic [1:0] op, input int len);
        int g = 0;
        req_valid = 1'b1;
        req_dest  = d;
        req_op    = op;
        req_len   = 8'(len);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) chk("req_timeout", 32'(req_ready), 32'(1));
        else begin
            pkt_hdr.push_back({2'b00, d, src_id, op});
            pkt_len.push_back(len);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ack(input bit rand_ready);
        int g = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [7:0] pd = 8'h00;
        while (ack !== 1'b1 && g < 400) begin
            if (pv && !pr) chk("valid_hold", 32'({send_valid, send_data}), 32'({1'b1, pd}));
            pv = send_valid;
            pd = send_data;
            if (rand_ready) send_ready = 1'($urandom_range(0, 1));
            pr = send_ready;
            @(negedge clk);
            g++;
        end
        chk("ack_seen", 32'({ack, send_valid}), 32'(2'b10));
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 32'(0));
        send_ready = 1'b1;
    endtask

    task automatic check_stream(input string tag);
        logic [7:0] exp_q[$];
        int n;
        while (pkt_len.size() > 0) begin
            int l = pkt_len.pop_front();
            exp_q.push_back(pkt_hdr.pop_front());
            for (int j = 0; j < l; j++) begin
                if (cons < pushed.size()) exp_q.push_back(pushed[cons]);
                cons++;
            end
            exp_acks++;
        end
        n = sent_q.size() - sent_base;
        chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(sent_q[sent_base + i]), 32'(exp_q[i]));
        sent_base = sent_q.size();
        chk({tag, "_acks"}, 32'(ack_cnt), 32'(exp_acks));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] basic_exp [4];
        logic [7:0] hdr;
        logic [7:0] b17;
        logic [1:0] d;
        logic [1:0] op;
        int occ, len, n;

        basic_exp = '{8'h27, 8'hA1, 8'hB2, 8'hC3};
        rst_n = 1'b0; src_id = 2'd1; req_valid = 1'b0; req_dest = 2'd0; req_op = 2'd0;
        req_len = 8'd0; pay_valid = 1'b0; pay_data = 8'h00; send_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_pay_ready", 32'(pay_ready), 32'(1));
        chk("rst_send", 32'({send_valid, send_data}), 32'(0));
        chk("rst_ack_busy_err", 32'({ack, busy, err_timeout}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic packet with exact cycle timing
        send_ready = 1'b1;
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
        request(2'd2, 2'd3, 3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_beat%0d", i), 32'({send_valid, send_data}), 32'({1'b1, basic_exp[i]}));
            @(negedge clk);
        end
        chk("basic_ack", 32'({ack, send_valid, req_ready}), 32'(3'b100));
        @(negedge clk);
        chk("basic_idle", 32'({ack, req_ready, busy}), 32'(3'b010));
        check_stream("basic");

        // Header-only with 5 cycles of backpressure
        send_ready = 1'b0;
        d = 2'($urandom); op = 2'($urandom);
        hdr = {2'b00, d, 2'd1, op};
        request(d, op, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hdr_hold%0d", i), 32'({send_valid, send_data}), 32'({1'b1, hdr}));
            @(negedge clk);
        end
        chk("hdr_last", 32'({send_valid, send_data}), 32'({1'b1, hdr}));
        send_ready = 1'b1;
        @(negedge clk);
        chk("hdr_ack", 32'({ack, send_valid}), 32'(2'b10));
        @(negedge clk);
        check_stream("hdronly");

        // FIFO full, 17th byte held off, then underflow during a 20-byte packet
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        b17 = 8'($urandom);
        pay_valid = 1'b1;
        pay_data  = b17;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("full_ready%0d", i), 32'(pay_ready), 32'(0));
            @(negedge clk);
        end
        pay_valid = 1'b0;
        request(2'($urandom), 2'($urandom), 20);
        repeat (18) @(negedge clk);
        chk("underflow_stall", 32'({send_valid, busy, ack, pay_ready}), 32'(4'b0101));
        push_byte(b17);
        chk("underflow_resume", 32'({send_valid, send_data}), 32'({1'b1, b17}));
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        wait_ack(1'b0);
        check_stream("len20");

        // Back-to-back packets sharing one queued burst
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        request(2'($urandom), 2'($urandom), 3);
        request(2'($urandom), 2'($urandom), 3);
        chk("b2b_gap", 32'(cyc - ack_cyc), 32'(2));
        wait_ack(1'b0);
        check_stream("b2b");

        // Randomized packets with random backpressure and leftover bytes
        for (int it = 0; it < 6; it++) begin
            src_id = 2'($urandom);
            occ = pushed.size() - cons;
            len = $urandom_range(0, 10);
            n = ((len > occ) ? (len - occ) : 0) + $urandom_range(0, 3);
            if (occ + n > 16) n = 16 - occ;
            for (int i = 0; i < n; i++) push_byte(8'($urandom));
            request(2'($urandom), 2'($urandom), len);
            wait_ack(1'b1);
            check_stream($sformatf("rand%0d", it));
        end

        // Reset in the middle of a payload
        src_id = 2'd1;
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        request(2'($urandom), 2'($urandom), 5);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_state", 32'({busy, req_ready, send_valid, ack, pay_ready}), 32'(5'b01001));
        chk("mrst_data", 32'(send_data), 32'(0));
        rst_n = 1'b1;
        pushed.delete(); cons = 0; pkt_hdr.delete(); pkt_len.delete();
        sent_base = sent_q.size();
        repeat (3) @(negedge clk);
        chk("mrst_no_ack", 32'(ack_cnt), 32'(exp_acks));
        chk("mrst_idle", 32'({busy, send_valid}), 32'(0));
        for (int i = 0; i < 2; i++) push_byte(8'($urandom));
        request(2'($urandom), 2'($urandom), 2);
        wait_ack(1'b0);
        check_stream("post_rst");

        chk("final_acks", 32'(ack_cnt), 32'(exp_acks));
        chk("final_err", 32'(err_timeout), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
